// File: rtl/video_pixel_feeder_if.sv
// Upstream pixel stream, timing-generator request/sync, and feeder status signals.
interface video_pixel_feeder_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 9
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_sof;
  logic              s_ready;
  logic              video_vs;
  logic              data_req;
  logic [DATA_W-1:0] pixel_data;
  logic [ADDR_W:0]   fifo_level;
  logic              underflow;
  logic              resync;

  modport master (
    output s_valid, s_data, s_sof, video_vs, data_req,
    input  s_ready, pixel_data, fifo_level, underflow, resync
  );

  modport slave (
    input  s_valid, s_data, s_sof, video_vs, data_req,
    output s_ready, pixel_data, fifo_level, underflow, resync
  );
endinterface

// File: rtl/video_pixel_feeder.sv
// FIFO-buffered pixel source for the HDMI timing generator with SOF alignment checking.
// Define VIDEO_PIXEL_FEEDER_STATS_EN to add saturating underflow/resync counters.
module video_pixel_feeder #(
  parameter int                DATA_W   = 24,
  parameter int                ADDR_W   = 9,
  parameter int                PREFETCH = 256,
  parameter int                H_DISP   = 1920,
  parameter int                V_DISP   = 1080,
  parameter logic [DATA_W-1:0] FILL_RGB = 24'h000000
) (
  input  logic                pixel_clk,
  input  logic                sys_rst,
`ifdef VIDEO_PIXEL_FEEDER_STATS_EN
  output logic [15:0]         underflow_cnt,
  output logic [7:0]          resync_cnt,
`endif
  video_pixel_feeder_if.slave vif
);

  localparam int              DEPTH          = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEVEL_FULL     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEVEL_PREFETCH = (ADDR_W+1)'((PREFETCH > DEPTH) ? DEPTH : PREFETCH);
  localparam logic [21:0]     LAST_PIX       = 22'(H_DISP*V_DISP-1);

  typedef enum logic [1:0] {ST_WAIT_VS, ST_FILL, ST_RUN, ST_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [21:0]       pix_cnt_q, pix_cnt_d;
  logic              vs_dly_q, vs_dly_d;
  logic [DATA_W-1:0] pixel_q, pixel_d;
  logic              underflow_q, underflow_d;
  logic              resync_q, resync_d;
  logic              s_ready_q, s_ready_d;

  logic [DATA_W:0]   fifo_mem [DEPTH];
  logic [DATA_W:0]   head;
  logic              wr_en, pop, empty, vs_fall;
  logic              run_req, run_pop, flush_pop, misalign, underrun;

  always_comb begin
    head      = fifo_mem[rd_ptr_q];
    empty     = (level_q == '0);
    wr_en     = vif.s_valid & s_ready_q;
    vs_fall   = vs_dly_q & ~vif.video_vs;
    run_req   = (state_q == ST_RUN) & vif.data_req;
    run_pop   = run_req & ~empty;
    underrun  = run_req & empty;
    flush_pop = (state_q == ST_FLUSH) & ~empty & ~head[DATA_W];
    pop       = run_pop | flush_pop;
    // SOF must coincide exactly with pixel 0; a vs fall mid-frame means the frame was short
    misalign  = (run_pop & head[DATA_W] & (pix_cnt_q != '0))
              | (run_pop & ~head[DATA_W] & (pix_cnt_q == '0))
              | ((state_q == ST_RUN) & vs_fall & (pix_cnt_q != '0));

    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    case (state_q)
      ST_WAIT_VS: if (vs_fall) state_d = ST_FILL;
      ST_FILL: begin
        pix_cnt_d = '0;
        if (level_q >= LEVEL_PREFETCH || level_q == LEVEL_FULL) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (misalign) begin
          state_d   = ST_FLUSH;
          pix_cnt_d = '0;
        end else if (run_req) begin
          if (pix_cnt_q == LAST_PIX) begin
            state_d   = ST_WAIT_VS;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + 22'd1;
          end
        end
      end
      // s_ready is low here, so an empty FIFO can never produce an SOF: give up and wait
      ST_FLUSH: if (empty || head[DATA_W]) state_d = ST_WAIT_VS;
      default: state_d = ST_WAIT_VS;
    endcase

    wr_ptr_d = wr_ptr_q + (wr_en ? ADDR_W'(1) : ADDR_W'(0));
    rd_ptr_d = rd_ptr_q + (pop ? ADDR_W'(1) : ADDR_W'(0));
    level_d  = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase

    s_ready_d = (level_d < LEVEL_FULL) && (state_d != ST_FLUSH);
    vs_dly_d  = vif.video_vs;

    pixel_d = pixel_q;
    if (vif.data_req) pixel_d = run_pop ? head[DATA_W-1:0] : FILL_RGB;

    underflow_d = underflow_q;
    if (underrun)     underflow_d = 1'b1;
    else if (vs_fall) underflow_d = 1'b0;

    resync_d = misalign;
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_WAIT_VS;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pix_cnt_q   <= '0;
      vs_dly_q    <= 1'b0;
      pixel_q     <= '0;
      underflow_q <= 1'b0;
      resync_q    <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pix_cnt_q   <= pix_cnt_d;
      vs_dly_q    <= vs_dly_d;
      pixel_q     <= pixel_d;
      underflow_q <= underflow_d;
      resync_q    <= resync_d;
      s_ready_q   <= s_ready_d;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= {vif.s_sof, vif.s_data};
  end

  assign vif.s_ready    = s_ready_q;
  assign vif.pixel_data = pixel_q;
  assign vif.fifo_level = level_q;
  assign vif.underflow  = underflow_q;
  assign vif.resync     = resync_q;

`ifdef VIDEO_PIXEL_FEEDER_STATS_EN
  logic [15:0] underflow_cnt_q, underflow_cnt_d;
  logic [7:0]  resync_cnt_q, resync_cnt_d;

  always_comb begin
    underflow_cnt_d = underflow_cnt_q;
    resync_cnt_d    = resync_cnt_q;
    if (underrun && underflow_cnt_q != 16'hFFFF) underflow_cnt_d = underflow_cnt_q + 16'd1;
    if (misalign && resync_cnt_q != 8'hFF)       resync_cnt_d    = resync_cnt_q + 8'd1;
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      underflow_cnt_q <= '0;
      resync_cnt_q    <= '0;
    end else begin
      underflow_cnt_q <= underflow_cnt_d;
      resync_cnt_q    <= resync_cnt_d;
    end
  end

  assign underflow_cnt = underflow_cnt_q;
  assign resync_cnt    = resync_cnt_q;
`endif

endmodule

// File: tb/tb_video_pixel_feeder.sv
// Randomized bench for video_pixel_feeder against a queue-based frame model.
module tb_video_pixel_feeder;
  localparam int                DATA_W   = 24;
  localparam int                ADDR_W   = 4;
  localparam int                DEPTH    = 16;
  localparam int                PREFETCH = 6;
  localparam int                H_DISP   = 4;
  localparam int                V_DISP   = 2;
  localparam int                FRAME    = H_DISP*V_DISP;
  localparam logic [DATA_W-1:0] FILL     = 24'hABCDEF;
  localparam int MD_IDLE = 0, MD_PRIME = 1, MD_PLAY = 2, MD_PURGE = 3;

  logic pixel_clk = 1'b0;
  logic sys_rst   = 1'b1;
  always #5 pixel_clk = ~pixel_clk;

  video_pixel_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) vif ();

`ifdef VIDEO_PIXEL_FEEDER_STATS_EN
  logic [15:0] underflow_cnt;
  logic [7:0]  resync_cnt;
`endif

  video_pixel_feeder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PREFETCH(PREFETCH),
    .H_DISP(H_DISP), .V_DISP(V_DISP), .FILL_RGB(FILL)
  ) dut (
    .pixel_clk(pixel_clk),
    .sys_rst(sys_rst),
`ifdef VIDEO_PIXEL_FEEDER_STATS_EN
    .underflow_cnt(underflow_cnt),
    .resync_cnt(resync_cnt),
`endif
    .vif(vif)
  );

  logic [DATA_W:0]   m_q[$];
  logic [DATA_W:0]   src_q[$];
  int                m_mode, m_pos, m_uf_cnt, m_rs_cnt;
  bit                m_rdy, m_uf, m_rs, m_vs_prev;
  logic [DATA_W-1:0] m_pix;
  int                n_cmp = 0;
  int                n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = MD_IDLE; m_pos = 0; m_rdy = 0; m_uf = 0; m_rs = 0; m_vs_prev = 0;
    m_pix = '0; m_uf_cnt = 0; m_rs_cnt = 0;
  endtask

  task automatic add_frame(input int len, input int extra_sof);
    for (int i = 0; i < len; i++)
      src_q.push_back({(i == 0) || (i == extra_sof), DATA_W'($urandom)});
  endtask

  task automatic drive(input int pv, input int pr, input bit vs_low);
    vif.s_valid = (src_q.size() > 0) && (int'($urandom_range(0, 99)) < pv);
    if (src_q.size() > 0) {vif.s_sof, vif.s_data} = src_q[0];
    else                  {vif.s_sof, vif.s_data} = {1'b0, DATA_W'($urandom)};
    vif.data_req = int'($urandom_range(0, 99)) < pr;
    vif.video_vs = ~vs_low;
  endtask

  // One clock: advance the model from the applied inputs, clock the DUT, compare.
  task automatic cycle();
    bit wr, req, fall, popped, bad;
    int nxt;
    logic [DATA_W:0] w;
    wr = vif.s_valid && m_rdy;
    req = vif.data_req;
    fall = m_vs_prev && !vif.video_vs;
    popped = 0; bad = 0; nxt = m_mode; w = '0;
    case (m_mode)
      MD_IDLE: if (fall) nxt = MD_PRIME;
      MD_PRIME: begin
        m_pos = 0;
        if (m_q.size() >= PREFETCH || m_q.size() == DEPTH) nxt = MD_PLAY;
      end
      MD_PLAY: begin
        if (req && m_q.size() > 0) begin w = m_q.pop_front(); popped = 1; end
        if (popped && (w[DATA_W] != (m_pos == 0))) bad = 1;
        if (fall && m_pos != 0) bad = 1;
        if (req && !popped) begin
          m_uf = 1;
          if (m_uf_cnt < 16'hFFFF) m_uf_cnt++;
        end
        if (bad) nxt = MD_PURGE;
        else if (req) begin
          m_pos++;
          if (m_pos == FRAME) begin nxt = MD_IDLE; m_pos = 0; end
        end
      end
      default: begin
        if (m_q.size() == 0 || m_q[0][DATA_W]) nxt = MD_IDLE;
        else void'(m_q.pop_front());
      end
    endcase
    if (fall && !(m_mode == MD_PLAY && req && !popped)) m_uf = 0;
    if (wr) begin
      m_q.push_back({vif.s_sof, vif.s_data});
      void'(src_q.pop_front());
    end
    if (req) m_pix = popped ? w[DATA_W-1:0] : FILL;
    m_rs = bad;
    if (bad && m_rs_cnt < 8'hFF) m_rs_cnt++;
    m_mode = nxt;
    m_vs_prev = vif.video_vs;
    m_rdy = (m_q.size() < DEPTH) && (m_mode != MD_PURGE);

    @(posedge pixel_clk);
    #1;
    chk("fifo_level", 32'(vif.fifo_level), 32'(m_q.size()));
    chk("s_ready", 32'(vif.s_ready), 32'(m_rdy));
    chk("pixel_data", 32'(vif.pixel_data), 32'(m_pix));
    chk("underflow", 32'(vif.underflow), 32'(m_uf));
    chk("resync", 32'(vif.resync), 32'(m_rs));
`ifdef VIDEO_PIXEL_FEEDER_STATS_EN
    chk("underflow_cnt", 32'(underflow_cnt), 32'(m_uf_cnt));
    chk("resync_cnt", 32'(resync_cnt), 32'(m_rs_cnt));
`endif
  endtask

  task automatic run(input int n, input int pv, input int pr, input int vs_per);
    for (int i = 0; i < n; i++) begin
      drive(pv, pr, (vs_per > 0) && ((i % vs_per) < 2));
      cycle();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"}, 32'(vif.fifo_level), 32'(0));
    chk({tag, "_s_ready"}, 32'(vif.s_ready), 32'(0));
    chk({tag, "_pixel"}, 32'(vif.pixel_data), 32'(0));
    chk({tag, "_underflow"}, 32'(vif.underflow), 32'(0));
    chk({tag, "_resync"}, 32'(vif.resync), 32'(0));
  endtask

  initial begin
    vif.s_valid = 0; vif.s_data = '0; vif.s_sof = 0; vif.data_req = 0; vif.video_vs = 1;
    model_reset();
    repeat (3) @(posedge pixel_clk);
    #1;
    check_reset_outputs("reset");
    sys_rst = 0;

    // Prefetch, then ordered pops of well-formed frames
    add_frame(FRAME, -1); add_frame(FRAME, -1); add_frame(FRAME, -1);
    run(30, 100, 0, 0);
    run(80, 80, 60, 40);

    // Short frame: FIFO drains mid-frame, requests underflow, vs fall clears the flag
    src_q.delete();
    run(20, 0, 0, 0);
    add_frame(5, -1);
    run(10, 100, 0, 0);
    run(12, 100, 0, 30);
    run(3, 0, 100, 0);
    run(20, 100, 0, 0);
    run(10, 0, 0, 8);

    // Misplaced SOF at pixel 5, then clean frames after the flush
    add_frame(FRAME, 5); add_frame(FRAME, -1); add_frame(FRAME, -1);
    run(150, 90, 50, 35);

    // Full FIFO with upstream held valid while popping
    for (int k = 0; k < 4; k++) add_frame(FRAME, -1);
    run(30, 100, 0, 0);
    run(100, 100, 50, 45);

    // Random soak: mixed good, misaligned and short frames with random vs timing
    for (int k = 0; k < 12; k++) begin
      for (int f = 0; f < 3; f++) begin
        case ($urandom_range(0, 5))
          0:       add_frame(FRAME, int'($urandom_range(1, FRAME-1)));
          1:       add_frame(int'($urandom_range(2, FRAME-1)), -1);
          default: add_frame(FRAME, -1);
        endcase
      end
      run(150, int'($urandom_range(40, 100)), int'($urandom_range(20, 90)),
          int'($urandom_range(15, 40)));
    end

    // Mid-frame reset with data queued: clears at once, then a clean restart
    add_frame(FRAME, -1); add_frame(FRAME, -1);
    run(20, 100, 0, 0);
    run(8, 100, 60, 25);
    sys_rst = 1;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    src_q.delete();
    vif.s_valid = 0; vif.data_req = 0; vif.video_vs = 1;
    repeat (2) @(posedge pixel_clk);
    #1;
    sys_rst = 0;
    add_frame(FRAME, -1); add_frame(FRAME, -1); add_frame(FRAME, -1);
    run(20, 100, 0, 0);
    run(120, 80, 60, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
